// File: rtl/systolic_ctrl_if.sv
// Control/handshake bundle between a job master and the systolic array sequencer.
// The master drives start/clear/len; the sequencer drives status, strobes and addresses.
interface systolic_ctrl_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic             start;
    logic             clear;
    logic [CNT_W-1:0] len;
    logic             ready;
    logic             busy;
    logic             done;
    logic             w_we;
    logic [AW-1:0]    w_addr;
    logic             a_rd;
    logic [CNT_W-1:0] a_addr;
    logic [N-1:0]     a_en;
    logic             y_we;
    logic [CNT_W-1:0] y_addr;

    modport master (
        output start, clear, len,
        input  ready, busy, done, w_we, w_addr, a_rd, a_addr, a_en, y_we, y_addr
    );

    modport slave (
        input  start, clear, len,
        output ready, busy, done, w_we, w_addr, a_rd, a_addr, a_en, y_we, y_addr
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN systolic array: loads weight rows, streams input vectors,
// skews per-row enables and drains results into the output buffer.
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 8,
    parameter int Y_LAT = N + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    systolic_ctrl_if.slave  bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;

    logic             w_a_rd;
    logic [CNT_W-1:0] w_a_addr;
    logic             w_w_we;

    logic [N-1:0]     r_aen;
    logic             r_yv  [Y_LAT];
    logic [CNT_W-1:0] r_yad [Y_LAT];
    logic             w_v_in [Y_LAT];
    logic [CNT_W-1:0] w_d_in [Y_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
        end else if (bus.clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD_W;
                        r_len   <= bus.len;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_cnt   <= '0;
                        r_state <= (r_len != '0) ? S_STREAM : S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    // r_len is nonzero here, so r_len-1 never underflows and the count stops before wrapping
                    if (r_cnt == r_len - 1'b1) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(Y_LAT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_w_we   = (r_state == S_LOAD_W);
    assign w_a_rd   = (r_state == S_STREAM);
    assign w_a_addr = w_a_rd ? r_cnt : '0;

    assign bus.ready  = (r_state == S_IDLE);
    assign bus.busy   = (r_state == S_LOAD_W) || (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.w_we   = w_w_we;
    assign bus.w_addr = w_w_we ? r_cnt[AW-1:0] : '0;
    assign bus.a_rd   = w_a_rd;
    assign bus.a_addr = w_a_addr;

    always_comb begin
        w_v_in[0] = w_a_rd;
        w_d_in[0] = w_a_addr;
        for (int unsigned i = 1; i < Y_LAT; i++) begin
            w_v_in[i] = r_yv[i-1];
            w_d_in[i] = r_yad[i-1];
        end
    end

    // Address stages only load alongside a valid bit, so the tail holds the last written address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aen <= '0;
            for (int unsigned i = 0; i < Y_LAT; i++) begin
                r_yv[i]  <= 1'b0;
                r_yad[i] <= '0;
            end
        end else if (bus.clear) begin
            r_aen <= '0;
            for (int unsigned i = 0; i < Y_LAT; i++) begin
                r_yv[i]  <= 1'b0;
                r_yad[i] <= '0;
            end
        end else begin
            r_aen[0] <= w_a_rd;
            for (int unsigned i = 1; i < N; i++) begin
                r_aen[i] <= r_aen[i-1];
            end
            for (int unsigned i = 0; i < Y_LAT; i++) begin
                r_yv[i] <= w_v_in[i];
                if (w_v_in[i]) begin
                    r_yad[i] <= w_d_in[i];
                end
            end
        end
    end

    assign bus.a_en   = r_aen;
    assign bus.y_we   = r_yv[Y_LAT-1];
    assign bus.y_addr = r_yad[Y_LAT-1];
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: a cycle-indexed job-schedule model checked every
// cycle, plus hand-computed literal timing points for directed scenarios.
module tb_systolic_ctrl;
    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int YL  = 5;
    localparam int HSZ = 8192;

    logic clk;
    logic rst_n;

    systolic_ctrl_if #(.N(N), .CNT_W(CW)) bus ();

    systolic_ctrl #(.N(N), .CNT_W(CW), .Y_LAT(YL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a job accepted in cycle s with length L is a fixed schedule in t = c - s;
    // delayed outputs look back into a per-cycle history of a_rd/a_addr, cut at clear/reset.
    int c = 0;
    int cut = 1;
    int s = 0;
    int L = 0;
    int dt = 0;
    bit job = 0;
    int hist_ard   [HSZ];
    int hist_aaddr [HSZ];
    int m_yaddr = 0;
    int m_ready, m_busy, m_done, m_wwe, m_waddr, m_ard, m_aaddr, m_aen, m_ywe;

    function automatic int dly(input int d);
        int idx;
        idx = c - d;
        if (idx < 0 || idx < cut) return 0;
        return hist_ard[idx % HSZ];
    endfunction

    task automatic model_outputs();
        int t;
        bit act;
        t = c - s;
        act = job && (t >= 1) && (t <= dt);
        m_ready = act ? 0 : 1;
        m_busy  = (act && t < dt) ? 1 : 0;
        m_done  = (act && t == dt) ? 1 : 0;
        m_wwe   = (act && t <= N) ? 1 : 0;
        m_waddr = m_wwe ? t - 1 : 0;
        m_ard   = hist_ard[c % HSZ];
        m_aaddr = hist_aaddr[c % HSZ];
        m_aen   = 0;
        for (int r = 0; r < N; r++) m_aen |= dly(1 + r) << r;
        m_ywe   = dly(YL);
    endtask

    initial begin
        int c_old, t;
        bit idle_old, strm;
        model_outputs();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                c++;
                cut = c + 1;
                job = 0;
                m_yaddr = 0;
                hist_ard[c % HSZ]   = 0;
                hist_aaddr[c % HSZ] = 0;
            end else begin
                idle_old = !job || (c - s > dt);
                c_old = c;
                c++;
                if (bus.clear) begin
                    job = 0;
                    cut = c;
                    m_yaddr = 0;
                end else if (idle_old && bus.start) begin
                    job = 1;
                    s = c_old;
                    L = int'(bus.len);
                    dt = (L > 0) ? N + L + YL + 1 : N + 1;
                end
                t = c - s;
                strm = job && (L > 0) && (t >= N + 1) && (t <= N + L);
                hist_ard[c % HSZ]   = strm ? 1 : 0;
                hist_aaddr[c % HSZ] = strm ? t - N - 1 : 0;
                if (dly(YL) != 0) m_yaddr = hist_aaddr[(c - YL) % HSZ];
            end
            model_outputs();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ready",  bus.ready,  m_ready);
            chk("busy",   bus.busy,   m_busy);
            chk("done",   bus.done,   m_done);
            chk("w_we",   bus.w_we,   m_wwe);
            chk("w_addr", bus.w_addr, m_waddr);
            chk("a_rd",   bus.a_rd,   m_ard);
            chk("a_addr", bus.a_addr, m_aaddr);
            chk("a_en",   bus.a_en,   m_aen);
            chk("y_we",   bus.y_we,   m_ywe);
            chk("y_addr", bus.y_addr, m_yaddr);
        end
    end

    int cyc = 0;
    int yw_cnt = 0;

    task automatic to_cyc(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
            yw_cnt += int'(bus.y_we);
        end
    endtask

    task automatic launch(input int l);
        #1;
        bus.start = 1'b1;
        bus.len   = CW'(l);
        cyc = 0;
        yw_cnt = 0;
    endtask

    // Nominal len=3 job already launched in cycle 0; optionally re-pulse start with len=9 mid-stream
    task automatic nominal(input string tag, input bit repulse);
        to_cyc(1);
        chk({tag, "_w_we1"}, bus.w_we, 1);
        chk({tag, "_w_addr1"}, bus.w_addr, 0);
        #1 bus.start = 1'b0;
        to_cyc(4);
        chk({tag, "_w_addr4"}, bus.w_addr, 3);
        to_cyc(5);
        chk({tag, "_a_rd5"}, bus.a_rd, 1);
        chk({tag, "_a_addr5"}, bus.a_addr, 0);
        to_cyc(6);
        if (repulse) begin
            #1 bus.start = 1'b1;
            bus.len = CW'(9);
        end
        to_cyc(7);
        chk({tag, "_a_addr7"}, bus.a_addr, 2);
        if (repulse) begin
            #1 bus.start = 1'b0;
            bus.len = CW'(3);
        end
        to_cyc(8);
        chk({tag, "_a_rd8"}, bus.a_rd, 0);
        chk({tag, "_a_en0_8"}, bus.a_en[0], 1);
        to_cyc(9);
        chk({tag, "_a_en3_9"}, bus.a_en[3], 1);
        to_cyc(10);
        chk({tag, "_y_we10"}, bus.y_we, 1);
        chk({tag, "_y_addr10"}, bus.y_addr, 0);
        to_cyc(12);
        chk({tag, "_y_addr12"}, bus.y_addr, 2);
        to_cyc(13);
        chk({tag, "_done13"}, bus.done, 1);
        to_cyc(14);
        chk({tag, "_ready14"}, bus.ready, 1);
        chk({tag, "_y_we_count"}, yw_cnt, 3);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.len   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_a_en", bus.a_en, 0);

        // start on the first edge after reset release
        #1 rst_n = 1'b1;
        bus.start = 1'b1;
        bus.len = CW'(3);
        cyc = 0;
        yw_cnt = 0;
        nominal("nom", 1'b0);

        // back-to-back: start in the first IDLE cycle after done
        launch(3);
        nominal("b2b", 1'b0);

        launch(0);
        to_cyc(1);
        #1 bus.start = 1'b0;
        to_cyc(4);
        chk("len0_w_addr4", bus.w_addr, 3);
        to_cyc(5);
        chk("len0_done5", bus.done, 1);
        chk("len0_a_rd5", bus.a_rd, 0);
        to_cyc(6);
        chk("len0_ready6", bus.ready, 1);
        chk("len0_y_we_count", yw_cnt, 0);

        launch(3);
        nominal("repulse", 1'b1);
        to_cyc(30);
        chk("repulse_y_we_total", yw_cnt, 3);

        launch(3);
        to_cyc(1);
        #1 bus.start = 1'b0;
        to_cyc(6);
        #1 bus.clear = 1'b1;
        to_cyc(7);
        chk("clr_ready7", bus.ready, 1);
        chk("clr_a_en7", bus.a_en, 0);
        chk("clr_y_we7", bus.y_we, 0);
        #1 bus.start = 1'b1;
        to_cyc(8);
        chk("clr_start_ready8", bus.ready, 1);
        chk("clr_start_busy8", bus.busy, 0);
        #1 bus.clear = 1'b0;
        bus.start = 1'b0;
        to_cyc(25);
        chk("clr_y_we_count", yw_cnt, 0);

        launch(3);
        to_cyc(1);
        #1 bus.start = 1'b0;
        to_cyc(8);
        chk("rstmid_a_en0_pre", bus.a_en[0], 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_ready", bus.ready, 1);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_a_en", bus.a_en, 0);
        chk("rstmid_a_rd", bus.a_rd, 0);
        chk("rstmid_a_addr", bus.a_addr, 0);
        to_cyc(10);
        #1 rst_n = 1'b1;
        bus.start = 1'b1;
        bus.len = CW'(3);
        cyc = 0;
        yw_cnt = 0;
        nominal("postrst", 1'b0);

        launch(255);
        to_cyc(1);
        #1 bus.start = 1'b0;
        to_cyc(259);
        chk("max_a_rd259", bus.a_rd, 1);
        chk("max_a_addr259", bus.a_addr, 254);
        to_cyc(260);
        chk("max_a_rd260", bus.a_rd, 0);
        chk("max_busy260", bus.busy, 1);
        to_cyc(265);
        chk("max_done265", bus.done, 1);
        to_cyc(266);
        chk("max_ready266", bus.ready, 1);
        chk("max_y_we_count", yw_cnt, 255);
        to_cyc(270);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (rows = columns = N).
REQ-002 SHALL have parameter CNT_W, default 8: width of vector count and buffer addresses.
REQ-003 SHALL have parameter Y_LAT, default 5 (N+1): cycles from a_rd for a vector to its y_we.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-007 SHALL have port clear  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-008 SHALL have port len  input  CNT_W  number of input vectors; latched when start is accepted.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have port busy  output  1  high in LOAD_W, STREAM and DRAIN.
REQ-011 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-012 SHALL have port w_we  output  1  weight-row write strobe to the PE array.
REQ-013 SHALL have port w_addr  output  clog2(N)  weight row being written.
REQ-014 SHALL have port a_rd  output  1  input-buffer read strobe (buffer read latency 1 cycle).
REQ-015 SHALL have port a_addr  output  CNT_W  input-buffer read address.
REQ-016 SHALL have port a_en  output  N  per-row skewed input enables into the array.
REQ-017 SHALL have port y_we  output  1  output-buffer write strobe.
REQ-018 SHALL have port y_addr  output  CNT_W  output-buffer write address.

Function
REQ-019 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-020 IDLE SHALL go to LOAD_W on start=1 and clear=0, latching len; otherwise it SHALL stay in IDLE.
REQ-021 LOAD_W SHALL last exactly N cycles with w_we=1 and w_addr=0,1,...,N-1.
REQ-022 At the end of LOAD_W the FSM SHALL go to STREAM if latched len>0, else directly to DONE.
REQ-023 STREAM SHALL last exactly len cycles with a_rd=1 and a_addr=0,1,...,len-1.
REQ-024 DRAIN SHALL last exactly Y_LAT cycles with a_rd=0, then go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 a_en[r] SHALL equal a_rd delayed by 1+r cycles, for r=0..N-1, using a shift register.
REQ-027 y_we SHALL equal a_rd delayed by Y_LAT cycles.
REQ-028 y_addr SHALL equal a_addr delayed by Y_LAT cycles; y_addr SHALL hold its last value while y_we=0.
REQ-029 start SHALL be ignored outside IDLE, and len SHALL NOT be re-latched while busy.
REQ-030 When clear=1 in any state, the next state SHALL be IDLE.
REQ-031 clear=1 SHALL zero all delay lines so that a_en and y_we are 0 on the next cycle.
REQ-032 clear=1 SHALL suppress done.
REQ-033 When clear and start are both 1 in IDLE, clear SHALL win and the FSM SHALL stay in IDLE.
REQ-034 Counters SHALL NOT wrap: len=2^CNT_W-1 SHALL stream addresses 0..2^CNT_W-2 exactly once.
REQ-035 ready, busy and done SHALL be mutually exclusive and decoded from the state register.

Reset
REQ-036 While rst_n=0, state SHALL be IDLE and ready SHALL be 1.
REQ-037 While rst_n=0, busy, done, w_we, a_rd, y_we SHALL be 0, and w_addr, a_addr, a_en, y_addr SHALL be 0.
REQ-038 While rst_n=0, all delay lines and counters SHALL be 0.
REQ-039 Reset assertion mid-job SHALL take effect immediately and asynchronously, with no done pulse afterwards.
REQ-040 After reset release the block SHALL accept start on the first rising edge.

Verification
REQ-041 Nominal job, N=4, Y_LAT=5, start at cycle 0 with len=3:
  - w_we at cycles 1-4, w_addr 0..3;
  - a_rd at cycles 5-7;
  - a_en[0] at 6-8 and a_en[3] at 9-11;
  - y_we at 10-12, y_addr 0..2;
  - done at cycle 13; ready at cycle 14.
REQ-042 len=0 -> LOAD_W at cycles 1-4, done at cycle 5; a_rd and y_we never asserted.
REQ-043 start re-pulsed with len=9 during STREAM -> ignored; exactly 3 y_we pulses; done at cycle 13.
REQ-044 clear at cycle 6 of the nominal job -> IDLE at cycle 7; a_en and y_we 0 from cycle 7; no done.
REQ-045 rst_n low at cycle 8 of the nominal job -> all outputs at reset values immediately.
REQ-046 After the REQ-045 reset is released, a new start SHALL complete with normal timing.
REQ-047 Back-to-back jobs: start asserted in the first IDLE cycle after done -> second job timing identical to the first.
